// File: rtl/wb_bus_arbiter_pkg.sv
// rtl/wb_bus_arbiter_pkg.sv - shared constants and helpers for the WISHBONE bus arbiter
//
// Purpose : FSM state encodings, default hold limit and the round-robin
//           index wrap helper used by the arbiter and its priority search.
// Ports   : none (package)
package wb_bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_GRANTED  = 2'b01;
  localparam logic [1:0] ST_REVOKED  = 2'b10;

  localparam int DEFAULT_MAX_HOLD    = 256;
  localparam int DEFAULT_N_BITS_HOLD = 9;

  // Wrap a master index into 0..n-1.
  function automatic int rr_wrap(input int v, input int n);
    return v % n;
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_rr_prio_select.sv
// rtl/wb_bus_arbiter_rr_prio_select.sv - combinational round-robin priority search
//
// Purpose : pick the first asserted request starting one past the pointer,
//           wrapping around the request vector.
// Ports   : req_i   - request vector (already masked by the caller)
//           ptr_i   - index of the previous owner
//           gnt_o   - one-hot winner, zero when nothing requests
//           idx_o   - binary index of the winner
//           valid_o - high when a winner was found
module rr_prio_select
  import wb_bus_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic          found;
  logic [IW-1:0] pos;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    // k runs 1..N so the previous owner is visited last.
    for (int k = 1; k <= N; k++) begin
      pos = IW'(rr_wrap(int'(ptr_i) + k, N));
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        idx_o      = pos;
        gnt_o[pos] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin WISHBONE bus arbiter with hold-time limit
//
// Purpose : grants the shared bus to one master at a time, round-robin,
//           revoking a grant held for MAX_HOLD cycles.
// Ports   : clk, rst    - clock, synchronous active-high reset
//           cyc_i       - per-master CYC request
//           gnt_o       - registered one-hot grant
//           gnt_id_o    - index of the granted (or last granted) master
//           bus_busy_o  - any grant active
//           timeout_o   - one-cycle pulse when a grant is revoked
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS   = 4,
  parameter int MAX_HOLD    = DEFAULT_MAX_HOLD,
  parameter int N_BITS_HOLD = DEFAULT_N_BITS_HOLD,
  localparam int IW         = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] cyc_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic [IW-1:0]        gnt_id_o,
  output logic                 bus_busy_o,
  output logic                 timeout_o
);

  logic [1:0]             state_q, state_d;
  logic [N_MASTERS-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]          gnt_id_q, gnt_id_d;
  logic [IW-1:0]          last_q, last_d;
  logic [N_BITS_HOLD-1:0] hold_q, hold_d;
  logic [N_MASTERS-1:0]   mask_q, mask_d;
  logic                   timeout_q, timeout_d;

  logic [N_MASTERS-1:0]   sel_gnt;
  logic [IW-1:0]          sel_idx;
  logic                   sel_valid;

  rr_prio_select #(
    .N  (N_MASTERS),
    .IW (IW)
  ) u_sel (
    .req_i   (cyc_i & ~mask_q),
    .ptr_i   (last_q),
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    last_d    = last_q;
    hold_d    = hold_q;
    // A revoked master stays masked until it lets go of CYC.
    mask_d    = mask_q & cyc_i;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_REVOKED: begin
        if (sel_valid) begin
          state_d  = ST_GRANTED;
          gnt_d    = sel_gnt;
          gnt_id_d = sel_idx;
          hold_d   = '0;
        end else if (state_q == ST_REVOKED && mask_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANTED: begin
        // Release is checked first so a drop on the last allowed cycle is not a timeout.
        if (!cyc_i[gnt_id_q]) begin
          gnt_d   = '0;
          last_d  = gnt_id_q;
          state_d = ST_IDLE;
        end else if (hold_q == N_BITS_HOLD'(MAX_HOLD - 1)) begin
          gnt_d     = '0;
          last_d    = gnt_id_q;
          timeout_d = 1'b1;
          mask_d    = mask_d | gnt_q;
          state_d   = ST_REVOKED;
        end else if (hold_q != N_BITS_HOLD'(MAX_HOLD)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      last_q    <= IW'(N_MASTERS - 1);
      hold_q    <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_id_o   = gnt_id_q;
  assign bus_busy_o = |gnt_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - self-checking bench for wb_bus_arbiter
module tb_wb_bus_arbiter;

  localparam int NM = 4;
  localparam int MH = 8;

  logic          clk;
  logic          rst;
  logic [NM-1:0] cyc;
  logic [NM-1:0] gnt_o;
  logic [1:0]    gnt_id_o;
  logic          bus_busy_o;
  logic          timeout_o;

  int checks;
  int errors;

  // Reference model: who owns the bus, how long, who is barred.
  int       m_owner;
  int       m_last;
  int       m_id;
  int       m_held;
  bit [3:0] m_mask;
  bit       m_tmo;

  wb_bus_arbiter #(
    .N_MASTERS   (NM),
    .MAX_HOLD    (MH),
    .N_BITS_HOLD (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cyc_i      (cyc),
    .gnt_o      (gnt_o),
    .gnt_id_o   (gnt_id_o),
    .bus_busy_o (bus_busy_o),
    .timeout_o  (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_gnt();
    logic [3:0] one;
    one = 4'b0001;
    return (m_owner >= 0) ? (one << m_owner) : 4'b0000;
  endfunction

  task automatic model_edge(input logic [3:0] c, input logic r);
    bit [3:0] nm;
    int       cand;
    if (r) begin
      m_owner = -1; m_last = NM - 1; m_id = 0; m_held = 0; m_mask = '0; m_tmo = 0;
    end else begin
      nm    = m_mask & c;
      m_tmo = 0;
      if (m_owner >= 0) begin
        if (!c[m_owner]) begin
          m_last  = m_owner;
          m_owner = -1;
        end else if (m_held + 1 == MH) begin
          m_tmo       = 1;
          m_last      = m_owner;
          nm[m_owner] = 1'b1;
          m_owner     = -1;
        end else begin
          m_held++;
        end
      end else begin
        for (int k = 1; k <= NM; k++) begin
          cand = (m_last + k) % NM;
          if (m_owner < 0 && c[cand] && !m_mask[cand]) begin
            m_owner = cand;
            m_id    = cand;
            m_held  = 0;
          end
        end
      end
      m_mask = nm;
    end
  endtask

  task automatic step(input logic [3:0] c, input logic r);
    cyc = c;
    rst = r;
    @(posedge clk);
    model_edge(c, r);
    #1;
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
  endtask

  task automatic test_reset();
    step(4'b0101, 1'b1);
    step(4'b0101, 1'b1);
    checks++;
    if (gnt_o !== 4'b0000 || gnt_id_o !== 2'd0 || bus_busy_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state gnt=%b id=%0d busy=%b tmo=%b expected 0000/0/0/0", gnt_o, gnt_id_o, bus_busy_o, timeout_o);
    end
    step(4'b0101, 1'b0);
    checks++;
    if (gnt_o !== 4'b0001 || gnt_id_o !== 2'd0 || bus_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_release gnt=%b id=%0d busy=%b expected 0001/0/1", gnt_o, gnt_id_o, bus_busy_o);
    end
  endtask

  task automatic test_release();
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0001, 1'b0);
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++;
      $display("FAIL release_hold gnt=%b expected 0001", gnt_o);
    end
    step(4'b0110, 1'b0);
    checks++;
    if (gnt_o !== 4'b0000 || gnt_id_o !== 2'd0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL release_idle gnt=%b id=%0d tmo=%b expected 0000/0/0", gnt_o, gnt_id_o, timeout_o);
    end
    step(4'b0110, 1'b0);
    checks++;
    if (gnt_o !== 4'b0010 || gnt_id_o !== 2'd1) begin
      errors++;
      $display("FAIL release_next gnt=%b id=%0d expected 0010/1", gnt_o, gnt_id_o);
    end
  endtask

  task automatic test_round_robin();
    int         order [5];
    logic [3:0] eg;
    logic [3:0] one;
    order = '{0, 1, 2, 3, 0};
    one   = 4'b0001;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      eg = one << order[t];
      for (int c = 0; c < 3; c++) begin
        step(4'b1111, 1'b0);
        checks++;
        if (gnt_o !== eg) begin
          errors++;
          $display("FAIL rr_turn%0d_cyc%0d gnt=%b expected %b", t, c, gnt_o, eg);
        end
      end
      step(4'b1111 & ~eg, 1'b0);
      checks++;
      if (gnt_o !== 4'b0000 || bus_busy_o !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d gnt=%b busy=%b expected 0000/0", t, gnt_o, bus_busy_o);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(4'b0100, 1'b0);
    for (int i = 0; i < MH - 1; i++) step(4'b1100, 1'b0);
    checks++;
    if (gnt_o !== 4'b0100 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_last_hold gnt=%b tmo=%b expected 0100/0", gnt_o, timeout_o);
    end
    step(4'b1100, 1'b0);
    checks++;
    if (gnt_o !== 4'b0000 || timeout_o !== 1'b1 || gnt_id_o !== 2'd2) begin
      errors++;
      $display("FAIL tmo_revoke gnt=%b tmo=%b id=%0d expected 0000/1/2", gnt_o, timeout_o, gnt_id_o);
    end
    step(4'b1100, 1'b0);
    checks++;
    if (gnt_o !== 4'b1000 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_next gnt=%b tmo=%b expected 1000/0", gnt_o, timeout_o);
    end
    step(4'b1100, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    checks++;
    if (gnt_o !== 4'b0000) begin
      errors++;
      $display("FAIL tmo_masked gnt=%b expected 0000", gnt_o);
    end
    step(4'b0000, 1'b0);
    step(4'b0100, 1'b0);
    checks++;
    if (gnt_o !== 4'b0100 || gnt_id_o !== 2'd2) begin
      errors++;
      $display("FAIL tmo_unmask gnt=%b id=%0d expected 0100/2", gnt_o, gnt_id_o);
    end
  endtask

  task automatic test_timeout_edge();
    do_reset();
    for (int i = 0; i < MH; i++) step(4'b0001, 1'b0);
    checks++;
    if (gnt_o !== 4'b0001) begin
      errors++;
      $display("FAIL edge_hold gnt=%b expected 0001", gnt_o);
    end
    step(4'b0000, 1'b0);
    checks++;
    if (gnt_o !== 4'b0000 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL edge_release gnt=%b tmo=%b expected 0000/0", gnt_o, timeout_o);
    end
    step(4'b0001, 1'b0);
    checks++;
    if (gnt_o !== 4'b0001 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL edge_regrant gnt=%b tmo=%b expected 0001/0", gnt_o, timeout_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    checks++;
    if (gnt_o !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_before gnt=%b expected 0010", gnt_o);
    end
    step(4'b0010, 1'b1);
    checks++;
    if (gnt_o !== 4'b0000 || bus_busy_o !== 1'b0 || gnt_id_o !== 2'd0) begin
      errors++;
      $display("FAIL midrst_clear gnt=%b busy=%b id=%0d expected 0000/0/0", gnt_o, bus_busy_o, gnt_id_o);
    end
    step(4'b0010, 1'b0);
    checks++;
    if (gnt_o !== 4'b0010 || gnt_id_o !== 2'd1) begin
      errors++;
      $display("FAIL midrst_regrant gnt=%b id=%0d expected 0010/1", gnt_o, gnt_id_o);
    end
  endtask

  task automatic test_random();
    logic [3:0] c;
    logic       r;
    logic [3:0] eg;
    c = 4'b0000;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NM; b++)
        if ($urandom_range(5) == 0) c[b] = ~c[b];
      r = ($urandom_range(199) == 0);
      step(c, r);
      eg = exp_gnt();
      checks++;
      if (gnt_o !== eg || gnt_id_o !== 2'(m_id) || bus_busy_o !== (eg != 4'b0000) || timeout_o !== m_tmo) begin
        errors++;
        $display("FAIL rand_cyc%0d gnt=%b id=%0d busy=%b tmo=%b expected %b/%0d/%b/%b",
                 i, gnt_o, gnt_id_o, bus_busy_o, timeout_o, eg, m_id, (eg != 4'b0000), m_tmo);
      end
      checks++;
      if ($countones(gnt_o) > 1) begin
        errors++;
        $display("FAIL rand_onehot%0d gnt=%b expected at most one bit", i, gnt_o);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = '0;
    rst    = 1'b1;
    m_owner = -1; m_last = NM - 1; m_id = 0; m_held = 0; m_mask = '0; m_tmo = 0;
    test_reset();
    test_release();
    test_round_robin();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
